// File: rtl/vn_sched_pkg.sv
// Shared decoder constants and the variable-node scheduler state encoding.
package vn_sched_pkg;

  localparam int unsigned NUM_VN_DEF = 64;
  localparam int unsigned ADDR_W_DEF = 6;
  localparam int unsigned MSG_W      = 11;
  localparam int unsigned ITER_W_DEF = 5;

  typedef enum logic [2:0] {
    IDLE,
    VN_PASS,
    VN_DRAIN,
    CN_WAIT,
    CHECK,
    FIN
  } vn_state_e;

endpackage

// File: rtl/vn_sched_addr_gen.sv
// Node address counter for a variable-node pass, plus the write address
// delayed by one cycle to line up with the RAM read latency.
module vn_sched_addr_gen
  import vn_sched_pkg::*;
#(
  parameter int unsigned NUM_VN = NUM_VN_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pass_c,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              last_c
);

  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

  // Counter restarts at 0 whenever a pass is entered (rd_en was low before).
  always_comb begin
    rd_en_d   = pass_c;
    rd_addr_d = '0;
    if (pass_c && rd_en_q) rd_addr_d = rd_addr_q + ADDR_W'(1);
    wr_en_d   = rd_en_q;
    wr_addr_d = rd_addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  assign last_c  = rd_en_q && (rd_addr_q == ADDR_W'(NUM_VN - 1));
  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;

endmodule

// File: rtl/vn_sched.sv
// Iteration scheduler for a time-shared variable-node datapath: sweeps all
// nodes, launches the check-node pass, and stops on syndrome OK or limit.
module vn_sched
  import vn_sched_pkg::*;
#(
  parameter int unsigned NUM_VN = NUM_VN_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned ITER_W = ITER_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ITER_W-1:0] max_iter,
  input  logic              cn_done,
  input  logic              syn_ok,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              cn_start,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic [ITER_W-1:0] iter_cnt
);

  vn_state_e         state_q, state_d;
  logic [ITER_W-1:0] limit_q, limit_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              conv_q, conv_d;
  logic              syn_q, syn_d;
  logic              cn_start_q, cn_start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_c;
  logic              last_c;

  always_comb begin
    state_d = state_q;
    limit_d = limit_q;
    iter_d  = iter_q;
    conv_d  = conv_q;
    syn_d   = syn_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          // A zero limit still runs one iteration.
          limit_d = (max_iter == '0) ? ITER_W'(1) : max_iter;
          iter_d  = '0;
          conv_d  = 1'b0;
          syn_d   = 1'b0;
          state_d = VN_PASS;
        end
      end
      VN_PASS:  if (last_c) state_d = VN_DRAIN;
      VN_DRAIN: state_d = CN_WAIT;
      CN_WAIT: begin
        if (cn_done) begin
          syn_d   = syn_ok;
          iter_d  = iter_q + ITER_W'(1);
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (syn_q) begin
          conv_d  = 1'b1;
          state_d = FIN;
        end else if (iter_q == limit_q) begin
          state_d = FIN;
        end else begin
          state_d = VN_PASS;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Status outputs are registered from the next state so they align with it.
    pass_c     = (state_d == VN_PASS);
    cn_start_d = (state_q == VN_DRAIN);
    busy_d     = (state_d == VN_PASS) || (state_d == VN_DRAIN) ||
                 (state_d == CN_WAIT) || (state_d == CHECK);
    done_d     = (state_d == FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      limit_q    <= '0;
      iter_q     <= '0;
      conv_q     <= 1'b0;
      syn_q      <= 1'b0;
      cn_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      limit_q    <= limit_d;
      iter_q     <= iter_d;
      conv_q     <= conv_d;
      syn_q      <= syn_d;
      cn_start_q <= cn_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  vn_sched_addr_gen #(
    .NUM_VN (NUM_VN),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .pass_c  (pass_c),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .last_c  (last_c)
  );

  assign cn_start  = cn_start_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign converged = conv_q;
  assign iter_cnt  = iter_q;

endmodule

// File: tb/tb_vn_sched.sv
// Directed bench for vn_sched with four nodes: decode scenarios from a table
// plus hand-written reset and back-to-back start sequences.
module tb_vn_sched;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 2;
  localparam int unsigned IW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [IW-1:0] max_iter;
  logic          cn_done;
  logic          syn_ok;
  logic          rd_en, wr_en, cn_start, busy, done, converged;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [IW-1:0] iter_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vn_sched #(.NUM_VN(N), .ADDR_W(AW), .ITER_W(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .max_iter  (max_iter),
    .cn_done   (cn_done),
    .syn_ok    (syn_ok),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .cn_start  (cn_start),
    .busy      (busy),
    .done      (done),
    .converged (converged),
    .iter_cnt  (iter_cnt)
  );

  typedef struct {
    int mi;       // max_iter applied with start
    int ok_at;    // iteration whose cn_done carries syn_ok=1 (0 = never)
    int lat;      // cycles from cn_start to cn_done
    bit spur;     // inject spurious cn_done / start inside the first pass
    int exp_iter;
    bit exp_conv;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"},  32'(rd_en), 0);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 0);
    chk({tag, "_wr_en"},  32'(wr_en), 0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
    chk({tag, "_cn_start"}, 32'(cn_start), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_conv"}, 32'(converged), 0);
    chk({tag, "_iter"}, 32'(iter_cnt), 0);
  endtask

  // One complete decode; returns in IDLE one cycle after the done pulse.
  task automatic run_decode(input vec_t v);
    start    = 1'b1;
    max_iter = IW'(v.mi);
    step();
    start = 1'b0;
    chk("acc_busy", 32'(busy), 1);
    chk("acc_iter", 32'(iter_cnt), 0);
    chk("acc_conv", 32'(converged), 0);
    for (int p = 1; p <= v.exp_iter; p++) begin
      for (int a = 0; a < int'(N); a++) begin
        chk("pass_rd_en", 32'(rd_en), 1);
        chk("pass_rd_addr", 32'(rd_addr), 32'(a));
        chk("pass_wr_en", 32'(wr_en), (a > 0) ? 1 : 0);
        if (a > 0) chk("pass_wr_addr", 32'(wr_addr), 32'(a - 1));
        chk("pass_cn_start", 32'(cn_start), 0);
        chk("pass_done", 32'(done), 0);
        cn_done = v.spur && p == 1 && a == 1;
        syn_ok  = cn_done;
        start   = v.spur && p == 1 && a == 2;
        step();
      end
      cn_done = 1'b0;
      syn_ok  = 1'b0;
      start   = 1'b0;
      chk("drain_rd_en", 32'(rd_en), 0);
      chk("drain_wr_en", 32'(wr_en), 1);
      chk("drain_wr_addr", 32'(wr_addr), 32'(N - 1));
      chk("drain_cn_start", 32'(cn_start), 0);
      step();
      chk("cn_start_pulse", 32'(cn_start), 1);
      chk("cn_start_rd_en", 32'(rd_en), 0);
      chk("cn_start_wr_en", 32'(wr_en), 0);
      start = v.spur;
      for (int k = 0; k < v.lat; k++) begin
        step();
        start = 1'b0;
        chk("wait_cn_start", 32'(cn_start), 0);
        chk("wait_rd_en", 32'(rd_en), 0);
        chk("wait_busy", 32'(busy), 1);
      end
      cn_done = 1'b1;
      syn_ok  = (p == v.ok_at);
      step();
      cn_done = 1'b0;
      syn_ok  = 1'b0;
      chk("check_iter", 32'(iter_cnt), 32'(p));
      chk("check_busy", 32'(busy), 1);
      chk("check_rd_en", 32'(rd_en), 0);
      step();
      if (p == v.exp_iter) begin
        chk("fin_done", 32'(done), 1);
        chk("fin_busy", 32'(busy), 0);
        chk("fin_conv", 32'(converged), 32'(v.exp_conv));
        chk("fin_iter", 32'(iter_cnt), 32'(v.exp_iter));
        chk("fin_rd_en", 32'(rd_en), 0);
      end else begin
        chk("again_done", 32'(done), 0);
      end
    end
    step();
    chk("idle_done", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_conv_hold", 32'(converged), 32'(v.exp_conv));
    chk("idle_iter_hold", 32'(iter_cnt), 32'(v.exp_iter));
  endtask

  initial begin
    vecs[0] = '{mi: 3, ok_at: 0, lat: 5, spur: 1'b0, exp_iter: 3, exp_conv: 1'b0};
    vecs[1] = '{mi: 3, ok_at: 1, lat: 5, spur: 1'b0, exp_iter: 1, exp_conv: 1'b1};
    vecs[2] = '{mi: 0, ok_at: 0, lat: 2, spur: 1'b1, exp_iter: 1, exp_conv: 1'b0};
    vecs[3] = '{mi: 4, ok_at: 2, lat: 0, spur: 1'b1, exp_iter: 2, exp_conv: 1'b1};
    vecs[4] = '{mi: 1, ok_at: 0, lat: 3, spur: 1'b0, exp_iter: 1, exp_conv: 1'b0};

    rst_n    = 1'b0;
    start    = 1'b0;
    max_iter = '0;
    cn_done  = 1'b0;
    syn_ok   = 1'b0;
    step();
    step();
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();
    chk_all_zero("post_reset_idle");

    // Decodes run back to back: each start lands in the cycle after done.
    for (int i = 0; i < 5; i++) run_decode(vecs[i]);

    // Reset while reading address 2 of the first pass.
    start    = 1'b1;
    max_iter = IW'(3);
    step();
    start = 1'b0;
    step();
    step();
    chk("pre_rst_rd_addr", 32'(rd_addr), 2);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_no_done", 32'(done), 0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("after_rst_idle_busy", 32'(busy), 0);
      chk("after_rst_no_done", 32'(done), 0);
    end
    run_decode(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global invariants checked every cycle away from the clock edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_en && cn_start) begin
        bad++;
        $display("FAIL rd_cn_overlap actual=1 required=0 t=%0t", $time);
      end
      if (done && busy) begin
        bad++;
        $display("FAIL done_busy_overlap actual=1 required=0 t=%0t", $time);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vn_sched.md
VN_SCHED -- requirements
Module: vn_sched

Interface
REQ-001 SHALL have parameter NUM_VN, default 64, number of variable nodes time-shared on one vn datapath.
REQ-002 SHALL have parameter ADDR_W, default 6, node address width (2**ADDR_W >= NUM_VN).
REQ-003 SHALL have parameter ITER_W, default 5, iteration counter width.
REQ-004 SHALL have ports:
  clk  input  1  sole clock, rising edge.
  rst_n  input  1  asynchronous active-low reset.
  start  input  1  one-cycle decode request.
  max_iter  input  ITER_W  iteration limit, sampled on accepted start.
  cn_done  input  1  check-node pass finished (pulse).
  syn_ok  input  1  all parity checks satisfied, valid when cn_done=1.
  rd_en  output  1  read message/belief RAMs at rd_addr.
  rd_addr  output  ADDR_W  node address being read.
  wr_en  output  1  write vn msg_out_1..3 back to message RAM.
  wr_addr  output  ADDR_W  node address being written.
  cn_start  output  1  one-cycle pulse launching check-node pass.
  busy  output  1  high from accepted start until done.
  done  output  1  one-cycle completion pulse.
  converged  output  1  result flag, valid with done, held until next start.
  iter_cnt  output  ITER_W  completed iterations, held until next start.

Function
REQ-005 SHALL implement FSM states IDLE, VN_PASS, VN_DRAIN, CN_WAIT, CHECK, FIN.
REQ-006 SHALL, in IDLE with start=1, capture max_iter (value 0 captured as 1), clear iter_cnt and converged, go to VN_PASS next cycle.
REQ-007 SHALL ignore start in every state other than IDLE.
REQ-008 SHALL, in VN_PASS, assert rd_en with rd_addr counting 0..NUM_VN-1, one address per cycle, no gaps.
REQ-009 SHALL model one-cycle RAM read latency: wr_en/wr_addr equal rd_en/rd_addr delayed by exactly one cycle.
REQ-010 SHALL, after rd_addr=NUM_VN-1, enter VN_DRAIN for one cycle (last write), then assert cn_start for one cycle and enter CN_WAIT.
REQ-011 SHALL remain in CN_WAIT indefinitely until cn_done=1; on that cycle register syn_ok and increment iter_cnt, go to CHECK.
REQ-012 SHALL, in CHECK: if registered syn_ok=1 set converged=1 and go to FIN; else if iter_cnt equals captured limit go to FIN with converged=0; else go to VN_PASS with rd_addr restarting at 0.
REQ-013 SHALL, in FIN, assert done for exactly one cycle, deassert busy the same cycle, return to IDLE.
REQ-014 SHALL ignore cn_done outside CN_WAIT.
REQ-015 SHALL never assert rd_en and cn_start together; rd_addr/wr_addr SHALL never exceed NUM_VN-1.
REQ-016 SHALL make all outputs registered; iter_cnt SHALL not wrap (limit <= 2**ITER_W-1 bounds it).
REQ-017 SHALL make start accepted in the cycle after done (IDLE) with no dead cycle.

Reset
REQ-018 SHALL, on rst_n low, immediately force IDLE and drive rd_en, wr_en, cn_start, busy, done, converged to 0, rd_addr, wr_addr, iter_cnt to 0.
REQ-019 SHALL abandon any in-progress decode on reset mid-operation; no done pulse results.
REQ-020 SHALL resume normal operation on the first clk edge after rst_n deasserts.

Structure
REQ-021 SHALL place FSM state enumeration and default NUM_VN/MSG_W(11)/ITER_W constants in the shared decoder package.
REQ-022 SHALL be a single module; optional sub-module vn_addr_gen (address counter + one-cycle write delay) is natural.
REQ-023 SHALL contain no message datapath; vn stays an external instance fed by RAM ports.

Verification
REQ-024 NUM_VN=4, max_iter=3, start, cn_done 5 cycles after each cn_start with syn_ok=0 -> three passes of rd_addr 0,1,2,3; done at end, iter_cnt=3, converged=0.
REQ-025 Same, syn_ok=1 on first cn_done -> single pass, done with iter_cnt=1, converged=1.
REQ-026 Any pass -> wr_en/wr_addr match rd_en/rd_addr shifted exactly one cycle; cn_start one cycle after last wr_en.
REQ-027 max_iter=0 -> exactly one iteration, iter_cnt=1; start pulsed mid-decode -> no effect on sequence.
REQ-028 rst_n low during VN_PASS at rd_addr=2 -> all outputs 0 asynchronously, no done; fresh start afterwards completes normally.
REQ-029 Spurious cn_done during VN_PASS -> ignored; start in cycle after done -> busy next cycle.
